// File: rtl/rect_sweep.sv
// Greedy 4x4 rectangle-flip reducer; latency 36*passes cycles, in_ready only when idle, result held until out_ready.
// Optional RECT_SWEEP_STATS_EN adds the flip_count port.
module rect_sweep #(
    parameter int MAX_PASSES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_matrix,
    output logic [15:0] flip_m,
    output logic [1:0]  flip_r1,
    output logic [1:0]  flip_r2,
    output logic [1:0]  flip_c1,
    output logic [1:0]  flip_c2,
    input  logic [15:0] flip_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_matrix,
    output logic [3:0]  out_passes
`ifdef RECT_SWEEP_STATS_EN
    ,
    output logic [7:0]  flip_count
`endif
);

    localparam logic [3:0] MAX_P  = 4'(MAX_PASSES);
    localparam logic [5:0] K_LAST = 6'd35;

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [15:0] cur_q, cur_d;
    logic [5:0]  k_q, k_d;
    logic [3:0]  pass_q, pass_d;
    logic        improved_q, improved_d;
`ifdef RECT_SWEEP_STATS_EN
    logic [7:0]  fc_q, fc_d;
`endif

    logic        accept;
    logic        last_rect;
    logic        more_pass;
    logic [5:0]  row_pair;
    logic [5:0]  col_pair;

    function automatic logic [4:0] popcnt(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
        return n;
    endfunction

    // Pair index -> {lo, hi} line numbers.
    function automatic logic [3:0] pair_dec(input logic [5:0] idx);
        case (idx)
            6'd0:    return {2'd0, 2'd1};
            6'd1:    return {2'd0, 2'd2};
            6'd2:    return {2'd0, 2'd3};
            6'd3:    return {2'd1, 2'd2};
            6'd4:    return {2'd1, 2'd3};
            default: return {2'd2, 2'd3};
        endcase
    endfunction

    always_comb begin
        if (k_q >= 6'd30)      row_pair = 6'd5;
        else if (k_q >= 6'd24) row_pair = 6'd4;
        else if (k_q >= 6'd18) row_pair = 6'd3;
        else if (k_q >= 6'd12) row_pair = 6'd2;
        else if (k_q >= 6'd6)  row_pair = 6'd1;
        else                   row_pair = 6'd0;
        col_pair = k_q - row_pair * 6'd6;
    end

    assign accept    = (state_q == SWEEP) && (popcnt(flip_result) < popcnt(cur_q));
    assign last_rect = (k_q == K_LAST);
    // An improvement in the final rectangle still earns another pass.
    assign more_pass = (improved_q || accept) && (pass_q < MAX_P);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            k_q        <= '0;
            pass_q     <= '0;
            improved_q <= 1'b0;
`ifdef RECT_SWEEP_STATS_EN
            fc_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            k_q        <= k_d;
            pass_q     <= pass_d;
            improved_q <= improved_d;
`ifdef RECT_SWEEP_STATS_EN
            fc_q       <= fc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SWEEP;
            SWEEP:   if (last_rect && !more_pass) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d      = cur_q;
        k_d        = k_q;
        pass_d     = pass_q;
        improved_d = improved_q;
`ifdef RECT_SWEEP_STATS_EN
        fc_d       = fc_q;
`endif
        if (state_q == IDLE && in_valid) begin
            cur_d      = in_matrix;
            k_d        = '0;
            pass_d     = 4'd1;
            improved_d = 1'b0;
`ifdef RECT_SWEEP_STATS_EN
            fc_d       = '0;
`endif
        end else if (state_q == SWEEP) begin
            if (accept) begin
                cur_d      = flip_result;
                improved_d = 1'b1;
`ifdef RECT_SWEEP_STATS_EN
                fc_d       = fc_q + 8'd1;
`endif
            end
            if (!last_rect) begin
                k_d = k_q + 6'd1;
            end else if (more_pass) begin
                k_d        = '0;
                pass_d     = pass_q + 4'd1;
                improved_d = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        flip_m     = cur_q;
        out_matrix = cur_q;
        out_passes = pass_q;
        flip_r1    = 2'd0;
        flip_r2    = 2'd0;
        flip_c1    = 2'd0;
        flip_c2    = 2'd0;
        if (state_q == SWEEP) begin
            {flip_r1, flip_r2} = pair_dec(row_pair);
            {flip_c1, flip_c2} = pair_dec(col_pair);
        end
    end

`ifdef RECT_SWEEP_STATS_EN
    assign flip_count = fc_q;
`endif

endmodule

// File: tb/tb_rect_sweep.sv
// Scoreboard bench for rect_sweep: a reference reducer predicts each result, a monitor checks outputs on handshake.
module tb_rect_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_matrix;
    logic [15:0] flip_m;
    logic [1:0]  flip_r1, flip_r2, flip_c1, flip_c2;
    logic [15:0] flip_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_matrix;
    logic [3:0]  out_passes;

    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [15:0] d1_in_matrix;
    logic [15:0] d1_flip_m;
    logic [1:0]  d1_r1, d1_r2, d1_c1, d1_c2;
    logic [15:0] d1_flip_result;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [15:0] d1_out_matrix;
    logic [3:0]  d1_out_passes;
`ifdef RECT_SWEEP_STATS_EN
    logic [7:0]  flip_count;
    logic [7:0]  d1_flip_count;
`endif

    logic rdy_force, rdy_val, rdy_rand;
    assign out_ready = rdy_force ? rdy_val : rdy_rand;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int plo[6] = '{0, 0, 0, 1, 1, 2};
    int phi[6] = '{1, 2, 3, 2, 3, 3};

    // Flip stage: invert the four corner cells of the rectangle.
    function automatic logic [15:0] flip4(input logic [15:0] m, input logic [1:0] r1, input logic [1:0] r2,
                                          input logic [1:0] c1, input logic [1:0] c2);
        logic [15:0] t;
        t = m;
        t[15 - (int'(c1) * 4 + int'(r1))] = ~t[15 - (int'(c1) * 4 + int'(r1))];
        t[15 - (int'(c2) * 4 + int'(r1))] = ~t[15 - (int'(c2) * 4 + int'(r1))];
        t[15 - (int'(c1) * 4 + int'(r2))] = ~t[15 - (int'(c1) * 4 + int'(r2))];
        t[15 - (int'(c2) * 4 + int'(r2))] = ~t[15 - (int'(c2) * 4 + int'(r2))];
        return t;
    endfunction

    assign flip_result    = flip4(flip_m, flip_r1, flip_r2, flip_c1, flip_c2);
    assign d1_flip_result = flip4(d1_flip_m, d1_r1, d1_r2, d1_c1, d1_c2);

    rect_sweep #(.MAX_PASSES(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_matrix(in_matrix),
        .flip_m(flip_m), .flip_r1(flip_r1), .flip_r2(flip_r2), .flip_c1(flip_c1), .flip_c2(flip_c2),
        .flip_result(flip_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_matrix(out_matrix), .out_passes(out_passes)
`ifdef RECT_SWEEP_STATS_EN
        , .flip_count(flip_count)
`endif
    );

    rect_sweep #(.MAX_PASSES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_matrix(d1_in_matrix),
        .flip_m(d1_flip_m), .flip_r1(d1_r1), .flip_r2(d1_r2), .flip_c1(d1_c1), .flip_c2(d1_c2),
        .flip_result(d1_flip_result), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_matrix(d1_out_matrix), .out_passes(d1_out_passes)
`ifdef RECT_SWEEP_STATS_EN
        , .flip_count(d1_flip_count)
`endif
    );

    typedef struct {
        logic [15:0] m;
        int          passes;
        int          flips;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Greedy reduction: repeat whole sweeps of all 36 rectangles while any flip lowered the cell count.
    task automatic ref_model(input logic [15:0] m, input int maxp, output logic [15:0] res,
                             output int passes, output int flips);
        logic [15:0] f;
        bit          imp;
        res = m; passes = 0; flips = 0;
        for (int p = 1; p <= maxp; p++) begin
            passes = p;
            imp = 0;
            for (int rp = 0; rp < 6; rp++)
                for (int cp = 0; cp < 6; cp++) begin
                    f = flip4(res, 2'(plo[rp]), 2'(phi[rp]), 2'(plo[cp]), 2'(phi[cp]));
                    if ($countones(f) < $countones(res)) begin
                        res = f; imp = 1; flips++;
                    end
                end
            if (!imp) break;
        end
    endtask

    always @(posedge clk) begin
        #1;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    logic prev_vld = 1'b0;
    int   vld_cyc  = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (out_valid && !prev_vld) vld_cyc = cyc;
            prev_vld = out_valid;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected no result", out_matrix);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_matrix", 32'(out_matrix), 32'(mon_e.m));
                    chk("out_passes", 32'(out_passes), mon_e.passes);
                    chk("latency", vld_cyc - mon_e.acc, 36 * mon_e.passes);
`ifdef RECT_SWEEP_STATS_EN
                    chk("flip_count", 32'(flip_count), mon_e.flips);
`endif
                end
            end
        end
    end

    task automatic send(input logic [15:0] m);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            return;
        end
        in_matrix = m;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_matrix = 16'($urandom);
        ref_model(m, 8, e.m, e.passes, e.flips);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    logic [15:0] em;
    int          ep, ef, acc1, n;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_matrix = '0;
        rdy_force = 1'b1; rdy_val = 1'b1; rdy_rand = 1'b1;
        d1_in_valid = 1'b0; d1_in_matrix = '0; d1_out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_matrix", 32'(out_matrix), 0);
        chk("rst_out_passes", 32'(out_passes), 0);
        chk("rst_flip_m", 32'(flip_m), 0);
        chk("rst_coords", 32'({flip_r1, flip_r2, flip_c1, flip_c2}), 0);
`ifdef RECT_SWEEP_STATS_EN
        chk("rst_flip_count", 32'(flip_count), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Empty matrix: full coordinate walk, no flips.
        send(16'h0000);
        for (int i = 0; i < 36; i++) begin
            chk("coords", 32'({flip_r1, flip_r2, flip_c1, flip_c2}),
                32'({2'(plo[i / 6]), 2'(phi[i / 6]), 2'(plo[i % 6]), 2'(phi[i % 6])}));
            chk("sweep_flip_m", 32'(flip_m), 0);
            @(negedge clk);
        end
        chk("done_out_valid", 32'(out_valid), 1);
        chk("done_coords", 32'({flip_r1, flip_r2, flip_c1, flip_c2}), 0);
        drain();

        send(16'hCC00);
        chk("cc00_k0_coords", 32'({flip_r1, flip_r2, flip_c1, flip_c2}), 32'h11);
        @(negedge clk);
        chk("cc00_after_k0", 32'(flip_m), 32'h0000);
        drain();

        send(16'hC800);
        @(negedge clk);
        chk("c800_after_k0", 32'(flip_m), 32'h0400);
        drain();

        // Single-pass instance stops after one sweep even though it improved.
        @(negedge clk);
        d1_in_matrix = 16'hCC00;
        d1_in_valid  = 1'b1;
        @(negedge clk);
        d1_in_valid  = 1'b0;
        acc1 = cyc;
        ref_model(16'hCC00, 1, em, ep, ef);
        n = 0;
        while (!d1_out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("d1_out_valid", 32'(d1_out_valid), 1);
        chk("d1_latency", cyc - acc1, 36 * ep);
        chk("d1_out_matrix", 32'(d1_out_matrix), 32'(em));
        chk("d1_out_passes", 32'(d1_out_passes), ep);
`ifdef RECT_SWEEP_STATS_EN
        chk("d1_flip_count", 32'(d1_flip_count), ef);
`endif
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        chk("d1_released", 32'(d1_out_valid), 0);

        // Consumer stall in DONE with in_valid pulses that must be ignored.
        rdy_val = 1'b0;
        send(16'hC800);
        n = 0;
        while (!out_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_out_matrix", 32'(out_matrix), 32'h0400);
            chk("hold_out_passes", 32'(out_passes), 2);
            chk("hold_in_ready", 32'(in_ready), 0);
`ifdef RECT_SWEEP_STATS_EN
            chk("hold_flip_count", 32'(flip_count), 1);
`endif
            in_valid  = (i % 2 == 0);
            in_matrix = 16'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_val  = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_out_valid", 32'(out_valid), 0);
        drain();

        // Reset in the middle of a sweep abandons the matrix.
        send(16'hCC00);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_flip_m", 32'(flip_m), 0);
        chk("midrst_out_passes", 32'(out_passes), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'hCC00);
        drain();

        // Randomised matrices with random consumer stalls.
        rdy_force = 1'b0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (i % 2 == 0) send(16'($urandom));
            else            send(16'($urandom & $urandom));
        end
        drain();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rect_sweep.md
RECT_SWEEP -- requirements
Module: rect_sweep

Interface
REQ-001 The module SHALL expose parameter MAX_PASSES, default 8, range 1..15, giving the maximum number of full rectangle sweeps per matrix.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit, meaning the input matrix is offered.
REQ-005 The module SHALL have port in_ready, output, 1 bit, meaning the module can accept a matrix.
REQ-006 The module SHALL have port in_matrix, input, 16 bits, the 4x4 matrix; cell (r,c) is at bit 15-(c*4+r).
REQ-007 The module SHALL have port flip_m, output, 16 bits, the current working matrix driven to the flip stage.
REQ-008 The module SHALL have ports flip_r1, flip_r2, flip_c1 and flip_c2, each output, 2 bits, the rectangle corners driven to the flip stage.
REQ-009 The module SHALL have port flip_result, input, 16 bits, the combinational flip-stage output for the current flip_m and coordinates.
REQ-010 The module SHALL have port out_valid, output, 1 bit, meaning the result is presented.
REQ-011 The module SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The module SHALL have port out_matrix, output, 16 bits, the reduced matrix.
REQ-013 The module SHALL have port out_passes, output, 4 bits, the number of sweeps executed.

Function
REQ-014 The FSM SHALL have states IDLE, SWEEP and DONE, and SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 In IDLE, on in_valid&&in_ready the module SHALL load cur<=in_matrix, set k=0, pass=1 and improved=0, then go to SWEEP.
REQ-016 The rectangle index k (0..35) SHALL be rowpair*6+colpair, with pairs ordered (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) as (r1,r2) or (c1,c2).
REQ-017 In SWEEP, the module SHALL evaluate exactly one rectangle per cycle: flip_m=cur and coordinates decoded from k.
REQ-018 In SWEEP, if popcount(flip_result) < popcount(cur), the module SHALL set cur<=flip_result and improved<=1 at the clock edge; otherwise cur SHALL be held.
REQ-019 At k=35, if (improved or this cycle accepts) and pass<MAX_PASSES, the module SHALL set k=0, pass+=1, improved=0 and stay in SWEEP; otherwise it SHALL go to DONE.
REQ-020 In DONE, out_matrix=cur and out_passes=pass SHALL stay stable while out_ready=0; on out_ready=1 the module SHALL go to IDLE.
REQ-021 Outside SWEEP, the coordinate outputs SHALL be 0 and flip_m SHALL equal cur.
REQ-022 The module SHALL ignore in_valid in SWEEP and DONE.
REQ-023 Latency SHALL be 36*P cycles from the accept edge to out_valid=1, where P is the final out_passes value.
REQ-024 A result accepted in DONE SHALL return to IDLE, and a new matrix SHALL be accepted no earlier than the next cycle.

Reset
REQ-025 When rst_n=0, the module SHALL asynchronously set state=IDLE, cur=0, k=0, pass=0 and improved=0.
REQ-026 When rst_n=0, outputs SHALL be in_ready=1, out_valid=0, out_matrix=0, out_passes=0, flip_m=0 and coordinates=0.
REQ-027 A reset asserted mid-SWEEP or in DONE SHALL abandon the matrix without emitting out_valid.

Configuration
REQ-028 With macro RECT_SWEEP_STATS_EN defined, the module SHALL add output port flip_count, 8 bits, holding the number of accepted flips for the current matrix.
REQ-029 flip_count SHALL clear on load and on reset, increment per accepted flip, and stay stable in DONE.
REQ-030 Without RECT_SWEEP_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL check: in_matrix=0x0000 -> 36 cycles with no flips; out_matrix=0x0000, out_passes=1, flip_count=0.
REQ-032 Bench SHALL check: in_matrix=0xCC00 -> flip accepted at k=0; out_matrix=0x0000, out_passes=2, flip_count=1, out_valid exactly 72 cycles after accept.
REQ-033 Bench SHALL check: in_matrix=0xC800 -> flip at k=0 gives 0x0400; out_matrix=0x0400, out_passes=2.
REQ-034 Bench SHALL check: MAX_PASSES=1, in_matrix=0xCC00 -> out_matrix=0x0000, out_passes=1 despite the improvement.
REQ-035 Bench SHALL check: out_ready held low 10 cycles in DONE -> out_valid=1, out_matrix stable and in_ready=0 throughout; in_valid pulses ignored.
REQ-036 Bench SHALL check: rst_n low at sweep cycle 10 -> out_valid=0, in_ready=1 and flip_m=0 immediately; a new 0xCC00 load then completes normally.
